bls12_381_axil_master: RTL and testbench

BLS12_381_AXIL_MASTER -- requirements
Module: bls12_381_axil_master

---
 rtl/bls12_381_axil_master_if.sv | 35 +++
 rtl/bls12_381_axil_master.sv | 184 ++++++++++++++++++
 tb/tb_bls12_381_axil_master.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bls12_381_axil_master_if.sv
// AXI-lite bundle (32-bit address/data) between the BLS12-381 initiator
// and the coprocessor bridge.
interface if_axi_lite;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport source (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid,
      input  arready, rdata, rresp, rvalid
   );

   modport sink (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arvalid, rready,
      output awready, wready, bresp, bvalid,
      output arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/bls12_381_axil_master.sv
// BLS12-381 AXI-lite initiator: multi-word requests as single-word beats.
// Watchdog compiled in with BLS12_381_AXIL_TIMEOUT_EN.
module bls12_381_axil_master #(
   parameter int MAX_WORDS   = 12,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   if_axi_lite.source              axi_lite_if,
   input  logic                    i_req_val,
   output logic                    o_req_rdy,
   input  logic                    i_req_wr,
   input  logic [31:0]             i_req_addr,
   input  logic [3:0]              i_req_words,
   input  logic [32*MAX_WORDS-1:0] i_req_data,
   output logic                    o_rsp_val,
   input  logic                    i_rsp_rdy,
   output logic [32*MAX_WORDS-1:0] o_rsp_data,
   output logic                    o_rsp_err
);

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RSP
   } state_t;

   localparam logic [3:0] MAXW = 4'(MAX_WORDS);

   state_t      state_q;
   state_t      state_d;
   logic        rdy_q;
   logic        err_q;
   logic        aw_done_q;
   logic        w_done_q;
   logic [31:0] base_q;
   logic [3:0]  cnt_q;
   logic [3:0]  k_q;
   logic [31:0] wbuf_q [MAX_WORDS];
   logic [31:0] rbuf_q [MAX_WORDS];

   logic awvalid, wvalid, bready, arvalid, rready;
   logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
   logic accept, bad, last, aw_all, timeout;

   assign accept = rdy_q & i_req_val;
   assign bad    = (i_req_words == 4'd0) || (i_req_words > MAXW) ||
                   (i_req_addr[1:0] != 2'b00);
   assign last   = (k_q + 4'd1) >= cnt_q;

   assign aw_fire = awvalid & axi_lite_if.awready;
   assign w_fire  = wvalid & axi_lite_if.wready;
   assign b_fire  = bready & axi_lite_if.bvalid;
   assign ar_fire = arvalid & axi_lite_if.arready;
   assign r_fire  = rready & axi_lite_if.rvalid;
   assign aw_all  = (aw_done_q | aw_fire) & (w_done_q | w_fire);

`ifdef BLS12_381_AXIL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] wd_q;
   logic          busy;
   logic          hs;

   assign busy = (state_q == WR_ADDR) || (state_q == WR_RESP) ||
                 (state_q == RD_ADDR) || (state_q == RD_DATA);
   assign hs   = aw_fire | w_fire | b_fire | ar_fire | r_fire;
   assign timeout = busy && !hs && (wd_q == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         wd_q <= '0;
      else if (hs || !busy || (state_d != state_q))
         wd_q <= '0;
      else
         wd_q <= wd_q + 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)
                     state_d = bad ? RSP : (i_req_wr ? WR_ADDR : RD_ADDR);
         WR_ADDR: if (aw_all) state_d = WR_RESP;
         WR_RESP: if (b_fire) state_d = last ? RSP : WR_ADDR;
         RD_ADDR: if (ar_fire) state_d = RD_DATA;
         RD_DATA: if (r_fire) state_d = last ? RSP : RD_ADDR;
         RSP:     if (i_rsp_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // watchdog recovery overrides any pending handshake
      if (timeout) state_d = RSP;
   end

   always_comb begin
      awvalid = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b0;
      arvalid = 1'b0;
      rready  = 1'b0;
      unique case (state_q)
         WR_ADDR: begin
            awvalid = !aw_done_q;
            wvalid  = !w_done_q;
         end
         WR_RESP: bready  = 1'b1;
         RD_ADDR: arvalid = 1'b1;
         RD_DATA: rready  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rdy_q     <= 1'b0;
         err_q     <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         base_q    <= '0;
         cnt_q     <= '0;
         k_q       <= '0;
         for (int i = 0; i < MAX_WORDS; i++) begin
            wbuf_q[i] <= '0;
            rbuf_q[i] <= '0;
         end
      end else begin
         rdy_q <= (state_d == IDLE);
         if (accept) begin
            base_q <= i_req_addr;
            cnt_q  <= i_req_words;
            k_q    <= '0;
            err_q  <= bad;
            for (int i = 0; i < MAX_WORDS; i++) begin
               wbuf_q[i] <= i_req_data[32*i +: 32];
               rbuf_q[i] <= '0;
            end
         end
         if ((state_q == WR_ADDR) && (state_d == WR_ADDR)) begin
            aw_done_q <= aw_done_q | aw_fire;
            w_done_q  <= w_done_q | w_fire;
         end else begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
         end
         if ((b_fire || r_fire) && !last)
            k_q <= k_q + 4'd1;
         if (r_fire)
            rbuf_q[k_q] <= axi_lite_if.rdata;
         if (b_fire && (axi_lite_if.bresp != 2'b00))
            err_q <= 1'b1;
         if (r_fire && (axi_lite_if.rresp != 2'b00))
            err_q <= 1'b1;
         if (timeout)
            err_q <= 1'b1;
      end
   end

   assign axi_lite_if.awaddr  = base_q + {26'd0, k_q, 2'b00};
   assign axi_lite_if.araddr  = base_q + {26'd0, k_q, 2'b00};
   assign axi_lite_if.wdata   = wbuf_q[k_q];
   assign axi_lite_if.wstrb   = 4'hF;
   assign axi_lite_if.awvalid = awvalid;
   assign axi_lite_if.wvalid  = wvalid;
   assign axi_lite_if.bready  = bready;
   assign axi_lite_if.arvalid = arvalid;
   assign axi_lite_if.rready  = rready;

   assign o_req_rdy = rdy_q;
   assign o_rsp_val = (state_q == RSP);
   assign o_rsp_err = err_q;

   for (genvar g = 0; g < MAX_WORDS; g++) begin : g_rsp
      assign o_rsp_data[32*g +: 32] = rbuf_q[g];
   end

endmodule

// File: tb/tb_bls12_381_axil_master.sv
// Directed bench for bls12_381_axil_master acting as the AXI-lite slave.
// Timeout branch follows BLS12_381_AXIL_TIMEOUT_EN.
module tb_bls12_381_axil_master;

   logic         clk;
   logic         rst_n;
   logic         req_val;
   logic         req_rdy;
   logic         req_wr;
   logic [31:0]  req_addr;
   logic [3:0]   req_words;
   logic [383:0] req_data;
   logic         rsp_val;
   logic         rsp_rdy;
   logic [383:0] rsp_data;
   logic         rsp_err;

   int npass = 0;
   int ntot  = 0;

   if_axi_lite axi();

   bls12_381_axil_master #(.MAX_WORDS(12), .TIMEOUT_CYC(16)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .axi_lite_if (axi),
      .i_req_val   (req_val),
      .o_req_rdy   (req_rdy),
      .i_req_wr    (req_wr),
      .i_req_addr  (req_addr),
      .i_req_words (req_words),
      .i_req_data  (req_data),
      .o_rsp_val   (rsp_val),
      .i_rsp_rdy   (rsp_rdy),
      .o_rsp_data  (rsp_data),
      .o_rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [383:0] obs,
                      input logic [383:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send_req(input logic wr, input logic [31:0] a,
                           input logic [3:0] n, input logic [383:0] d);
      int t;
      t = 0;
      while (!req_rdy && t < 64) begin
         @(negedge clk);
         t++;
      end
      chk("req_rdy", req_rdy, 1);
      req_val = 1'b1;
      req_wr = wr;
      req_addr = a;
      req_words = n;
      req_data = d;
      @(negedge clk);
      req_val = 1'b0;
      chk("req_taken", req_rdy, 0);
   endtask

   task automatic wr_word(input logic [31:0] ea, input logic [31:0] ed,
                          input int awd, input int wdd,
                          input logic [1:0] resp, input bit do_b);
      int t, naw, nw;
      t = 0;
      naw = 0;
      nw = 0;
      while ((naw == 0 || nw == 0) && t < 64) begin
         axi.awready = (t >= awd);
         axi.wready = (t >= wdd);
         #1;
         if (axi.awvalid && axi.awready) begin
            naw++;
            chk("awaddr", axi.awaddr, ea);
         end
         if (axi.wvalid && axi.wready) begin
            nw++;
            chk("wdata", axi.wdata, ed);
         end
         @(negedge clk);
         t++;
      end
      axi.awready = 1'b0;
      axi.wready = 1'b0;
      chk("aw_w_once", {naw == 1, nw == 1}, 2'b11);
      chk("b_phase", {axi.bready, axi.awvalid, axi.wvalid}, 3'b100);
      if (do_b) begin
         axi.bvalid = 1'b1;
         axi.bresp = resp;
         @(negedge clk);
         axi.bvalid = 1'b0;
         axi.bresp = 2'b00;
      end
   endtask

   task automatic rd_word(input logic [31:0] ea, input logic [31:0] rd,
                          input int ard, input logic [1:0] resp);
      int t, nar;
      t = 0;
      nar = 0;
      while (nar == 0 && t < 64) begin
         axi.arready = (t >= ard);
         #1;
         if (axi.arvalid && axi.arready) begin
            nar++;
            chk("araddr", axi.araddr, ea);
         end
         @(negedge clk);
         t++;
      end
      axi.arready = 1'b0;
      chk("ar_once", nar, 1);
      chk("r_phase", {axi.rready, axi.arvalid}, 2'b10);
      axi.rvalid = 1'b1;
      axi.rdata = rd;
      axi.rresp = resp;
      @(negedge clk);
      axi.rvalid = 1'b0;
      axi.rresp = 2'b00;
   endtask

   task automatic expect_rsp(input string tag, input logic [383:0] ed,
                             input logic ee);
      int t;
      t = 0;
      while (!rsp_val && t < 64) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_val"}, rsp_val, 1);
      chk({tag, "_data"}, rsp_data, ed);
      chk({tag, "_err"}, rsp_err, ee);
      @(negedge clk);
      chk({tag, "_hold"}, {rsp_val, rsp_err, rsp_data}, {1'b1, ee, ed});
      rsp_rdy = 1'b1;
      @(negedge clk);
      rsp_rdy = 1'b0;
      chk({tag, "_done"}, {rsp_val, req_rdy}, 2'b01);
   endtask

   task automatic bad_req(input string tag, input logic wr,
                          input logic [31:0] a, input logic [3:0] n);
      send_req(wr, a, n, '1);
      chk({tag, "_quiet"}, {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b000);
      chk({tag, "_now"}, rsp_val, 1);
      expect_rsp(tag, '0, 1'b1);
   endtask

   initial begin
      logic [383:0] d;
      logic [383:0] e;
      int n;
      rst_n = 1'b0;
      req_val = 1'b0;
      req_wr = 1'b0;
      req_addr = '0;
      req_words = '0;
      req_data = '0;
      rsp_rdy = 1'b0;
      axi.awready = 1'b0;
      axi.wready = 1'b0;
      axi.bvalid = 1'b0;
      axi.bresp = 2'b00;
      axi.arready = 1'b0;
      axi.rvalid = 1'b0;
      axi.rdata = '0;
      axi.rresp = 2'b00;
      repeat (2) @(negedge clk);

      chk("rst_rdy", req_rdy, 0);
      chk("rst_ctl", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid,
                      axi.rready, rsp_val, rsp_err}, 7'd0);
      chk("rst_bus", {axi.awaddr, axi.araddr, axi.wdata}, 96'd0);
      chk("rst_wstrb", axi.wstrb, 4'hF);
      chk("rst_rsp_data", rsp_data, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_after_rst", req_rdy, 1);

      // 12-word write, immediate readies
      d = '0;
      for (int k = 0; k < 12; k++) d[32*k +: 32] = 32'(k + 1);
      send_req(1'b1, 32'h2000, 4'd12, d);
      for (int k = 0; k < 12; k++)
         wr_word(32'h2000 + 32'(4 * k), 32'(k + 1), 0, 0, 2'b00, 1'b1);
      expect_rsp("wr12", '0, 1'b0);

      // 3-word read, arready delayed
      send_req(1'b0, 32'h1000, 4'd3, '1);
      rd_word(32'h1000, 32'hAAAA_0001, 5, 2'b00);
      rd_word(32'h1004, 32'hBBBB_0002, 0, 2'b00);
      rd_word(32'h1008, 32'hCCCC_0003, 0, 2'b00);
      e = '0;
      e[31:0] = 32'hAAAA_0001;
      e[63:32] = 32'hBBBB_0002;
      e[95:64] = 32'hCCCC_0003;
      expect_rsp("rd3", e, 1'b0);

      // skewed AW/W readies in both orders
      d = '0;
      d[31:0] = 32'hBEEF_0001;
      d[63:32] = 32'hBEEF_0002;
      send_req(1'b1, 32'h40, 4'd2, d);
      wr_word(32'h40, 32'hBEEF_0001, 0, 3, 2'b00, 1'b1);
      wr_word(32'h44, 32'hBEEF_0002, 3, 0, 2'b00, 1'b1);
      expect_rsp("wr_skew", '0, 1'b0);

      // SLVERR on second read word
      send_req(1'b0, 32'h500, 4'd2, '0);
      rd_word(32'h500, 32'h11, 0, 2'b00);
      rd_word(32'h504, 32'h22, 0, 2'b10);
      e = '0;
      e[31:0] = 32'h11;
      e[63:32] = 32'h22;
      expect_rsp("rd_slverr", e, 1'b1);

      // non-OKAY write response
      d = '0;
      d[31:0] = 32'h5A5A_A5A5;
      send_req(1'b1, 32'h80, 4'd1, d);
      wr_word(32'h80, 32'h5A5A_A5A5, 1, 1, 2'b11, 1'b1);
      expect_rsp("wr_decerr", '0, 1'b1);

      // address wrap past the top of the map
      send_req(1'b0, 32'hFFFF_FFFC, 4'd2, '0);
      rd_word(32'hFFFF_FFFC, 32'h0000_0005, 0, 2'b00);
      rd_word(32'h0000_0000, 32'h0000_0006, 0, 2'b00);
      e = '0;
      e[31:0] = 32'h5;
      e[63:32] = 32'h6;
      expect_rsp("rd_wrap", e, 1'b0);

      bad_req("bad_cnt0", 1'b0, 32'h1000, 4'd0);
      bad_req("bad_cnt13", 1'b1, 32'h1000, 4'd13);
      bad_req("bad_align", 1'b0, 32'h1002, 4'd3);

      // reset in WR_RESP of word 5
      d = '0;
      for (int k = 0; k < 12; k++) d[32*k +: 32] = 32'(k + 1);
      send_req(1'b1, 32'h2000, 4'd12, d);
      for (int k = 0; k < 5; k++)
         wr_word(32'h2000 + 32'(4 * k), 32'(k + 1), 0, 0, 2'b00, 1'b1);
      wr_word(32'h2014, 32'd6, 0, 0, 2'b00, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ctl", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid,
                          axi.rready, rsp_val, req_rdy}, 7'd0);
      chk("mid_rst_bus", {axi.awaddr, axi.wdata}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_rdy", {req_rdy, rsp_val}, 2'b10);
      n = 0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_val || axi.awvalid || axi.bready) n++;
      end
      chk("mid_rst_quiet", n, 0);

      // stalled arready
      send_req(1'b0, 32'h3000, 4'd1, '0);
`ifdef BLS12_381_AXIL_TIMEOUT_EN
      n = 0;
      while (axi.arvalid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("wd_cycles", n, 16);
      chk("wd_quiet", {axi.arvalid, axi.rready}, 2'b00);
      expect_rsp("wd", '0, 1'b1);
`else
      repeat (1000) @(negedge clk);
      chk("no_wd_arvalid", {axi.arvalid, rsp_val}, 2'b10);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("no_wd_recover", req_rdy, 1);
`endif

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
